// File: rtl/kmeans_pkg.sv
// Shared types and constants for the k-means centroid-update path.
package kmeans_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LD,
    S_WAIT,
    S_WR,
    S_DONE
  } state_e;

  localparam int unsigned K_DEF       = 8;
  localparam int unsigned D_DEF       = 7;
  localparam int unsigned SUM_W_DEF   = 32;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned COORD_W_DEF = 8;
  localparam int unsigned DIV_LAT_DEF = 4;

  // Clamp an unsigned value to the largest number representable in w bits.
  function automatic logic [63:0] saturate(input logic [63:0] q, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'(1) << w) - 64'(1));
    return (q > lim) ? lim : q;
  endfunction

endpackage

// File: rtl/div_hold_counter.sv
// Loadable down-counter that times how long the divider inputs are held.
module div_hold_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/centroid_div_scheduler.sv
// Walks every (cluster, dimension) pair, feeds sum/count through the shared divider
// and writes the saturated quotient back as the new centroid coordinate.
module centroid_div_scheduler
  import kmeans_pkg::*;
#(
  parameter int unsigned K             = K_DEF,
  parameter int unsigned D             = D_DEF,
  parameter int unsigned SUM_W         = SUM_W_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF,
  parameter int unsigned COORD_W       = COORD_W_DEF,
  parameter int unsigned DIV_LAT       = DIV_LAT_DEF,
  parameter bit          ROUND_NEAREST = 1'b0,
  localparam int unsigned KW           = (K > 1) ? $clog2(K) : 1,
  localparam int unsigned DW           = (D > 1) ? $clog2(D) : 1,
  localparam int unsigned AW           = SUM_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               sum_rd_en,
  output logic [KW-1:0]      sum_rd_cluster,
  output logic [DW-1:0]      sum_rd_dim,
  input  logic [SUM_W-1:0]   sum_rd_data,
  input  logic [CNT_W-1:0]   cnt_rd_data,
  output logic [AW-1:0]      div_a,
  output logic [AW-1:0]      div_b,
  input  logic [AW-1:0]      div_quotient,
  input  logic               div_by_0,
  output logic               cent_wr_en,
  output logic [KW-1:0]      cent_wr_cluster,
  output logic [DW-1:0]      cent_wr_dim,
  output logic [COORD_W-1:0] cent_wr_data,
  output logic [K-1:0]       empty_mask
);

  localparam int unsigned CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) + 1 : 1;

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [DW-1:0]      d_q, d_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic [AW-1:0]      div_a_q, div_a_d;
  logic [AW-1:0]      div_b_q, div_b_d;
  logic               wr_en_q, wr_en_d;
  logic [COORD_W-1:0] wr_data_q, wr_data_d;
  logic [K-1:0]       empty_q, empty_d;

  logic               hold_load_c;
  logic               hold_expired_c;
  logic [AW-1:0]      dividend_c;
  logic [COORD_W-1:0] sat_quot_c;

  div_hold_counter #(.W(CW)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hold_load_c),
    .load_val  (CW'(DIV_LAT - 1)),
    .en        (state_q == S_WAIT),
    .expired_c (hold_expired_c)
  );

  // Optional half-up rounding is folded into the dividend; AW has one spare bit for the carry.
  assign dividend_c = AW'(sum_rd_data) + (ROUND_NEAREST ? AW'(cnt_rd_data >> 1) : AW'(0));
  assign sat_quot_c = COORD_W'(saturate(64'(div_quotient), COORD_W));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    d_d         = d_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    empty_d     = empty_q;
    hold_load_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
          k_d     = '0;
          d_d     = '0;
          empty_d = '0;
        end
      end
      S_RD: state_d = S_LD;
      S_LD: begin
        state_d     = S_WAIT;
        div_a_d     = dividend_c;
        div_b_d     = AW'(cnt_rd_data);
        hold_load_c = 1'b1;
      end
      S_WAIT: begin
        // Quotient is sampled on the edge that ends the hold window; WR presents the result.
        if (hold_expired_c) begin
          state_d = S_WR;
          if (div_by_0) begin
            empty_d[k_q] = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_data_d = sat_quot_c;
          end
        end
      end
      S_WR: begin
        if (d_q == DW'(D - 1)) begin
          d_d = '0;
          if (k_q == KW'(K - 1)) begin
            k_d     = '0;
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = S_RD;
            rd_en_d = 1'b1;
          end
        end else begin
          d_d     = d_q + DW'(1);
          state_d = S_RD;
          rd_en_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      d_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      empty_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      d_q       <= d_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      empty_q   <= empty_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign sum_rd_en       = rd_en_q;
  assign sum_rd_cluster  = k_q;
  assign sum_rd_dim      = d_q;
  assign div_a           = div_a_q;
  assign div_b           = div_b_q;
  assign cent_wr_en      = wr_en_q;
  assign cent_wr_cluster = k_q;
  assign cent_wr_dim     = d_q;
  assign cent_wr_data    = wr_data_q;
  assign empty_mask      = empty_q;

endmodule

// File: tb/tb_centroid_div_scheduler.sv
// Scoreboard bench: a truncating and a rounding scheduler run side by side against
// an arithmetic reference of the centroid update.
module tb_centroid_div_scheduler;

  localparam int unsigned K       = 2;
  localparam int unsigned D       = 2;
  localparam int unsigned SUM_W   = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned COORD_W = 8;
  localparam int unsigned DIV_LAT = 4;
  localparam int unsigned AW      = SUM_W + 1;
  localparam int          N_DONE  = K * D * (3 + DIV_LAT) + 1;

  typedef struct {
    int k;
    int d;
    int v;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [SUM_W-1:0]   sums [K][D];
  logic [CNT_W-1:0]   cnts [K];

  logic               busy [2];
  logic               done [2];
  logic               rd_en [2];
  logic [0:0]         rd_k [2];
  logic [0:0]         rd_d [2];
  logic [SUM_W-1:0]   rd_sum [2];
  logic [CNT_W-1:0]   rd_cnt [2];
  logic [AW-1:0]      div_a [2];
  logic [AW-1:0]      div_b [2];
  logic [AW-1:0]      quo [2];
  logic               dz [2];
  logic               wr_en [2];
  logic [0:0]         wr_k [2];
  logic [0:0]         wr_d [2];
  logic [COORD_W-1:0] wr_data [2];
  logic [K-1:0]       emask [2];

  wr_t          exp0[$];
  wr_t          exp1[$];
  logic [K-1:0] exp_mask [2];
  int           n_done [2];
  int           n_cmp = 0;
  int           n_fail = 0;

  centroid_div_scheduler #(
    .K(K), .D(D), .SUM_W(SUM_W), .CNT_W(CNT_W), .COORD_W(COORD_W),
    .DIV_LAT(DIV_LAT), .ROUND_NEAREST(1'b0)
  ) u_trunc (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]), .done(done[0]),
    .sum_rd_en(rd_en[0]), .sum_rd_cluster(rd_k[0]), .sum_rd_dim(rd_d[0]),
    .sum_rd_data(rd_sum[0]), .cnt_rd_data(rd_cnt[0]),
    .div_a(div_a[0]), .div_b(div_b[0]), .div_quotient(quo[0]), .div_by_0(dz[0]),
    .cent_wr_en(wr_en[0]), .cent_wr_cluster(wr_k[0]), .cent_wr_dim(wr_d[0]),
    .cent_wr_data(wr_data[0]), .empty_mask(emask[0])
  );

  centroid_div_scheduler #(
    .K(K), .D(D), .SUM_W(SUM_W), .CNT_W(CNT_W), .COORD_W(COORD_W),
    .DIV_LAT(DIV_LAT), .ROUND_NEAREST(1'b1)
  ) u_round (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[1]), .done(done[1]),
    .sum_rd_en(rd_en[1]), .sum_rd_cluster(rd_k[1]), .sum_rd_dim(rd_d[1]),
    .sum_rd_data(rd_sum[1]), .cnt_rd_data(rd_cnt[1]),
    .div_a(div_a[1]), .div_b(div_b[1]), .div_quotient(quo[1]), .div_by_0(dz[1]),
    .cent_wr_en(wr_en[1]), .cent_wr_cluster(wr_k[1]), .cent_wr_dim(wr_d[1]),
    .cent_wr_data(wr_data[1]), .empty_mask(emask[1])
  );

  // Accumulator bank: one-cycle read latency.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rd_en[g]) begin
        rd_sum[g] <= sums[rd_k[g]][rd_d[g]];
        rd_cnt[g] <= cnts[rd_k[g]];
      end
    end
  end

  // Behavioural unsigned divider.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      quo[g] = (div_b[g] == '0) ? '1 : div_a[g] / div_b[g];
      dz[g]  = (div_b[g] == '0);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic check_write(input int g);
    wr_t e;
    bit  have;
    have = 1'b0;
    if (g == 0 && exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
    if (g == 1 && exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
    if (!have) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_write dut%0d: got (%0d,%0d)=%0d required no write",
               g, wr_k[g], wr_d[g], wr_data[g]);
    end else begin
      check($sformatf("write_dut%0d", g), {54'd0, wr_k[g], wr_d[g], wr_data[g]},
            64'((e.k << 9) | (e.d << 8) | e.v));
    end
  endtask

  // Monitor: every centroid write is matched against the head of the scoreboard.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (wr_en[g]) check_write(g);
      if (done[g]) n_done[g]++;
    end
  end

  // Reference: new coordinate = min(floor((sum [+ cnt/2]) / cnt), 2**COORD_W-1); cnt 0 marks empty.
  task automatic build_expect();
    longint unsigned num, q;
    wr_t e;
    for (int g = 0; g < 2; g++) begin
      exp_mask[g] = '0;
      for (int k = 0; k < int'(K); k++) begin
        for (int d = 0; d < int'(D); d++) begin
          if (cnts[k] == '0) begin
            exp_mask[g][k] = 1'b1;
          end else begin
            num = 64'(sums[k][d]) + ((g == 1) ? 64'(cnts[k] / 2) : 64'd0);
            q   = num / 64'(cnts[k]);
            if (q > 255) q = 255;
            e.k = k;
            e.d = d;
            e.v = int'(q);
            if (g == 0) exp0.push_back(e);
            else exp1.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic set_data(input int s00, input int s01, input int s10, input int s11,
                          input int c0, input int c1);
    sums[0][0] = SUM_W'(s00);
    sums[0][1] = SUM_W'(s01);
    sums[1][0] = SUM_W'(s10);
    sums[1][1] = SUM_W'(s11);
    cnts[0]    = CNT_W'(c0);
    cnts[1]    = CNT_W'(c1);
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_ctrl_dut%0d", tag, g),
            64'({busy[g], done[g], rd_en[g], rd_k[g], rd_d[g], wr_en[g], wr_k[g], wr_d[g],
                 wr_data[g], emask[g]}), 64'd0);
      check($sformatf("%s_div_dut%0d", tag, g), 64'({div_a[g], div_b[g]}), 64'd0);
    end
  endtask

  task automatic run_once(input string tag, input bit poke);
    int cyc;
    int d0;
    bit busy_drop;
    build_expect();
    d0 = n_done[0];
    busy_drop = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, "_busy_after_start"}, 64'(busy[0]), 64'd1);
    check({tag, "_mask_cleared"}, 64'({emask[0], emask[1]}), 64'd0);
    while (!done[0] && cyc < 200) begin
      if (!busy[0]) busy_drop = 1'b1;
      start = (poke && (cyc == 12 || cyc == 20)) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 64'(cyc), 64'(N_DONE));
    check({tag, "_busy_held"}, 64'(busy_drop), 64'd0);
    check({tag, "_done_round_dut"}, 64'(done[1]), 64'd1);
    check({tag, "_busy_at_done"}, 64'({busy[0], busy[1]}), 64'd0);
    check({tag, "_mask_trunc"}, 64'(emask[0]), 64'(exp_mask[0]));
    check({tag, "_mask_round"}, 64'(emask[1]), 64'(exp_mask[1]));
    // start during the DONE cycle must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_idle_after_done"}, 64'({busy[0], busy[1], done[0]}), 64'd0);
    check({tag, "_single_done"}, 64'(n_done[0] - d0), 64'd1);
    check({tag, "_pending_writes"}, 64'(exp0.size() + exp1.size()), 64'd0);
    check({tag, "_mask_hold"}, 64'(emask[0]), 64'(exp_mask[0]));
  endtask

  initial begin
    n_done[0] = 0;
    n_done[1] = 0;
    set_data(0, 0, 0, 0, 1, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    set_data(10, 20, 9, 3, 2, 3);
    run_once("basic", 1'b0);
    set_data(10, 20, 9, 3, 2, 0);
    run_once("empty_c1", 1'b0);
    set_data(9, 4, 7, 8, 2, 3);
    run_once("rounding", 1'b0);
    set_data(1000, 255, 1023, 1024, 1, 4);
    run_once("saturate", 1'b0);
    set_data(10, 20, 9, 3, 2, 3);
    run_once("start_busy", 1'b1);
    run_once("restart", 1'b0);
    set_data(0, 5, 7, 0, 0, 0);
    run_once("all_empty", 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < int'(K); k++) begin
        if ($urandom_range(0, 3) == 0) cnts[k] = '0;
        else if ($urandom_range(0, 1) == 1) cnts[k] = CNT_W'($urandom_range(1, 20));
        else cnts[k] = CNT_W'($urandom_range(1, 65535));
        for (int d = 0; d < int'(D); d++) begin
          if ($urandom_range(0, 1) == 1) sums[k][d] = SUM_W'($urandom_range(0, 3000));
          else sums[k][d] = SUM_W'($urandom());
        end
      end
      run_once($sformatf("rand%0d", r), 1'b0);
    end

    // Reset in the hold window of the second element.
    set_data(10, 20, 9, 3, 2, 3);
    build_expect();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    check("midrun_unwritten", 64'(exp0.size()), 64'd3);
    exp0.delete();
    exp1.delete();
    repeat (20) @(negedge clk);
    check_all_zero("held_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 64'({busy[0], busy[1]}), 64'd0);
    run_once("after_reset", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
